// File: rtl/multi_sampler.sv
// Double-banked multi-channel microphone frame capture.
// One bank fills while the consumer reads the other; overruns refill in place.
module multi_sampler #(
    parameter int N_CH            = 4,
    parameter int DATA_WIDTH      = 16,
    parameter int SAMPLES_PER_BUF = 256,
    parameter int ADDR_WIDTH      = $clog2(SAMPLES_PER_BUF),
    parameter int CH_W            = $clog2(N_CH > 1 ? N_CH : 2)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [N_CH*DATA_WIDTH-1:0] mic_data_i,
    input  logic                       mic_valid_i,
    input  logic [CH_W-1:0]            rd_ch_i,
    input  logic [ADDR_WIDTH-1:0]      rd_addr_i,
    input  logic                       rd_en_i,
    input  logic                       buf_release_i,
    input  logic                       ovr_clr_i,
    output logic [DATA_WIDTH-1:0]      rd_data_o,
    output logic                       rd_data_valid_o,
    output logic                       buf_ready_pulse_o,
    output logic                       active_buf_o,
    output logic                       pending_o,
    output logic                       overrun_o,
    output logic [15:0]                overrun_cnt_o
);

    localparam int CI = $clog2(N_CH > 1 ? N_CH : 2);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(SAMPLES_PER_BUF - 1);

    typedef enum logic {FREE, HELD} state_t;

    state_t state_q, state_d;

    logic [DATA_WIDTH-1:0] mem [2][N_CH][SAMPLES_PER_BUF];
    logic [ADDR_WIDTH-1:0] wr_idx;
    logic                  active;
    logic                  complete;
    logic                  swap;
    logic                  ovr_evt;
    logic [CI-1:0]         ch_idx;
    logic                  ch_ok;

    assign complete = mic_valid_i && (wr_idx == LAST);
    assign ch_idx   = CI'(rd_ch_i);
    assign ch_ok    = 32'(rd_ch_i) < 32'(N_CH);

    // Bank storage carries no reset; only the write strobe is gated by it.
    always_ff @(posedge clk_i) begin
        if (!rst_i && mic_valid_i) begin
            for (int k = 0; k < N_CH; k++) begin
                mem[active][k][wr_idx] <= mic_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= FREE;
        end else begin
            state_q <= state_d;
        end
    end

    // A release arriving with a completion frees the held bank just in time.
    always_comb begin
        state_d = state_q;
        swap    = 1'b0;
        ovr_evt = 1'b0;
        unique case (state_q)
            FREE: begin
                if (complete) begin
                    swap    = 1'b1;
                    state_d = HELD;
                end
            end
            HELD: begin
                if (complete) begin
                    if (buf_release_i) begin
                        swap = 1'b1;
                    end else begin
                        ovr_evt = 1'b1;
                    end
                end else if (buf_release_i) begin
                    state_d = FREE;
                end
            end
            default: state_d = FREE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_idx            <= '0;
            active            <= 1'b0;
            buf_ready_pulse_o <= 1'b0;
            overrun_o         <= 1'b0;
            overrun_cnt_o     <= '0;
        end else begin
            if (mic_valid_i) begin
                wr_idx <= wr_idx + 1'b1;
            end
            active            <= active ^ swap;
            buf_ready_pulse_o <= swap;
            if (ovr_clr_i) begin
                overrun_o     <= 1'b0;
                overrun_cnt_o <= '0;
            end else if (ovr_evt) begin
                overrun_o <= 1'b1;
                if (overrun_cnt_o != 16'hFFFF) begin
                    overrun_cnt_o <= overrun_cnt_o + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_data_o       <= '0;
            rd_data_valid_o <= 1'b0;
        end else begin
            rd_data_valid_o <= rd_en_i;
            if (rd_en_i) begin
                rd_data_o <= ch_ok ? mem[~active][ch_idx][rd_addr_i] : '0;
            end
        end
    end

    assign active_buf_o = active;
    assign pending_o    = (state_q == HELD);

endmodule

// File: tb/tb_multi_sampler.sv
// Directed scenario bench for multi_sampler (4 channels, 256-frame banks).
module tb_multi_sampler;

    logic        clk;
    logic        rst;
    logic [63:0] mic_data;
    logic        mic_valid;
    logic [2:0]  rd_ch;
    logic [7:0]  rd_addr;
    logic        rd_en;
    logic        buf_release;
    logic        ovr_clr;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        pulse;
    logic        active;
    logic        pending;
    logic        overrun;
    logic [15:0] ovr_cnt;

    int errors = 0;
    int checks = 0;
    int pulse_cnt = 0;

    multi_sampler #(
        .N_CH(4), .DATA_WIDTH(16), .SAMPLES_PER_BUF(256),
        .ADDR_WIDTH(8), .CH_W(3)
    ) dut (
        .clk_i(clk), .rst_i(rst), .mic_data_i(mic_data),
        .mic_valid_i(mic_valid), .rd_ch_i(rd_ch), .rd_addr_i(rd_addr),
        .rd_en_i(rd_en), .buf_release_i(buf_release), .ovr_clr_i(ovr_clr),
        .rd_data_o(rd_data), .rd_data_valid_o(rd_valid),
        .buf_ready_pulse_o(pulse), .active_buf_o(active),
        .pending_o(pending), .overrun_o(overrun), .overrun_cnt_o(ovr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (pulse === 1'b1) pulse_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [15:0] base, input int i,
                         input logic rel, input logic clr);
        for (int k = 0; k < 4; k++) mic_data[k*16 +: 16] = base + 16'(16*i + k);
        mic_valid = 1'b1;
        buf_release = rel;
        ovr_clr = clr;
        tick();
        mic_valid = 1'b0;
        buf_release = 1'b0;
        ovr_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (active !== 1'b0 || pending !== 1'b0 || pulse !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: active=%b pending=%b pulse=%b want 0 0 0", active, pending, pulse);
        end
        checks++;
        if (overrun !== 1'b0 || ovr_cnt !== 16'h0) begin
            errors++;
            $display("FAIL reset_ovr: overrun=%b cnt=%h want 0 0000", overrun, ovr_cnt);
        end
        checks++;
        if (rd_data !== 16'h0 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_rd: data=%h valid=%b want 0000 0", rd_data, rd_valid);
        end
    endtask

    task automatic test_fill_a();
        for (int i = 0; i < 255; i++) frame(16'h5000, i, 1'b0, 1'b0);
        checks++;
        if (pulse !== 1'b0) begin
            errors++;
            $display("FAIL early_pulse: pulse=%b want 0", pulse);
        end
        frame(16'h5000, 255, 1'b0, 1'b0);
        checks++;
        if (pulse !== 1'b1 || active !== 1'b1 || pending !== 1'b1) begin
            errors++;
            $display("FAIL fill_a: pulse=%b active=%b pending=%b want 1 1 1", pulse, active, pending);
        end
        rd_en = 1'b1;
        rd_ch = 3'd2;
        rd_addr = 8'd10;
        tick();
        rd_en = 1'b0;
        rd_addr = 8'd11;
        checks++;
        if (rd_data !== 16'h50A2 || rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL read_a: data=%h valid=%b want 50a2 1", rd_data, rd_valid);
        end
        tick();
        checks++;
        if (rd_data !== 16'h50A2 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL read_hold: data=%h valid=%b want 50a2 0", rd_data, rd_valid);
        end
        checks++;
        if (pulse_cnt !== 1) begin
            errors++;
            $display("FAIL pulse_once_a: count=%0d want 1", pulse_cnt);
        end
    endtask

    task automatic test_fill_b_gaps();
        int p0;
        buf_release = 1'b1;
        tick();
        buf_release = 1'b0;
        checks++;
        if (pending !== 1'b0) begin
            errors++;
            $display("FAIL release: pending=%b want 0", pending);
        end
        p0 = pulse_cnt;
        for (int i = 0; i < 256; i++) begin
            if (i % 3 == 1) tick();
            frame(16'h6000, i, 1'b0, 1'b0);
        end
        tick();
        checks++;
        if (pulse_cnt - p0 !== 1 || active !== 1'b0 || pending !== 1'b1) begin
            errors++;
            $display("FAIL fill_b: pulses=%0d active=%b pending=%b want 1 0 1", pulse_cnt - p0, active, pending);
        end
        for (int c = 0; c < 4; c++) begin
            for (int a = 0; a < 256; a++) begin
                rd_en = 1'b1;
                rd_ch = 3'(c);
                rd_addr = 8'(a);
                tick();
                checks++;
                if (rd_data !== 16'h6000 + 16'(16*a + c) || rd_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL bank_b ch%0d addr%0d: data=%h valid=%b want %h 1",
                             c, a, rd_data, rd_valid, 16'h6000 + 16'(16*a + c));
                end
            end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_overrun();
        int p0;
        p0 = pulse_cnt;
        for (int b = 0; b < 3; b++)
            for (int i = 0; i < 256; i++) frame(16'h7000, i, 1'b0, 1'b0);
        tick();
        checks++;
        if (pulse_cnt !== p0 || overrun !== 1'b1 || ovr_cnt !== 16'd3) begin
            errors++;
            $display("FAIL overrun: pulses=%0d overrun=%b cnt=%0d want 0 1 3", pulse_cnt - p0, overrun, ovr_cnt);
        end
        checks++;
        if (active !== 1'b0 || pending !== 1'b1) begin
            errors++;
            $display("FAIL overrun_bank: active=%b pending=%b want 0 1", active, pending);
        end
        for (int a = 0; a < 256; a += 5) begin
            rd_en = 1'b1;
            rd_ch = 3'(a % 4);
            rd_addr = 8'(a);
            tick();
            checks++;
            if (rd_data !== 16'h6000 + 16'(16*a + a % 4)) begin
                errors++;
                $display("FAIL bank_b_intact addr%0d: data=%h want %h", a, rd_data, 16'h6000 + 16'(16*a + a % 4));
            end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_release_with_complete();
        for (int i = 0; i < 255; i++) frame(16'h9000, i, 1'b0, 1'b0);
        frame(16'h9000, 255, 1'b1, 1'b0);
        checks++;
        if (pulse !== 1'b1 || active !== 1'b1 || pending !== 1'b1) begin
            errors++;
            $display("FAIL rel_complete: pulse=%b active=%b pending=%b want 1 1 1", pulse, active, pending);
        end
        checks++;
        if (ovr_cnt !== 16'd3 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL rel_complete_ovr: cnt=%0d overrun=%b want 3 1", ovr_cnt, overrun);
        end
    endtask

    task automatic test_reset_mid_fill();
        buf_release = 1'b1;
        tick();
        buf_release = 1'b0;
        for (int i = 0; i < 100; i++) frame(16'hA000, i, 1'b0, 1'b0);
        rst = 1'b1;
        mic_valid = 1'b1;
        mic_data = {4{16'hDEAD}};
        rd_en = 1'b1;
        ovr_clr = 1'b0;
        tick();
        rst = 1'b0;
        mic_valid = 1'b0;
        rd_en = 1'b0;
        checks++;
        if (active !== 1'b0 || pending !== 1'b0 || pulse !== 1'b0 ||
            overrun !== 1'b0 || ovr_cnt !== 16'h0) begin
            errors++;
            $display("FAIL mid_reset_ctrl: active=%b pending=%b pulse=%b ovr=%b cnt=%h want 0 0 0 0 0000",
                     active, pending, pulse, overrun, ovr_cnt);
        end
        checks++;
        if (rd_data !== 16'h0 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_rd: data=%h valid=%b want 0000 0", rd_data, rd_valid);
        end
        for (int i = 0; i < 255; i++) frame(16'h8000, i, 1'b0, 1'b0);
        checks++;
        if (pulse !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_early: pulse=%b want 0", pulse);
        end
        frame(16'h8000, 255, 1'b0, 1'b0);
        checks++;
        if (pulse !== 1'b1 || active !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_fill: pulse=%b active=%b want 1 1", pulse, active);
        end
        rd_en = 1'b1;
        rd_ch = 3'd1;
        rd_addr = 8'd0;
        tick();
        checks++;
        if (rd_data !== 16'h8001) begin
            errors++;
            $display("FAIL post_reset_idx0: data=%h want 8001", rd_data);
        end
        rd_ch = 3'd3;
        rd_addr = 8'd255;
        tick();
        rd_en = 1'b0;
        checks++;
        if (rd_data !== 16'h8FF3) begin
            errors++;
            $display("FAIL post_reset_last: data=%h want 8ff3", rd_data);
        end
    endtask

    task automatic test_ovr_clr_and_bad_ch();
        for (int i = 0; i < 256; i++) frame(16'hB000, i, 1'b0, 1'b0);
        checks++;
        if (overrun !== 1'b1 || ovr_cnt !== 16'd1) begin
            errors++;
            $display("FAIL ovr_one: overrun=%b cnt=%0d want 1 1", overrun, ovr_cnt);
        end
        for (int i = 0; i < 255; i++) frame(16'hB000, i, 1'b0, 1'b0);
        frame(16'hB000, 255, 1'b0, 1'b1);
        checks++;
        if (overrun !== 1'b0 || ovr_cnt !== 16'd0) begin
            errors++;
            $display("FAIL ovr_clr_wins: overrun=%b cnt=%0d want 0 0", overrun, ovr_cnt);
        end
        rd_en = 1'b1;
        rd_ch = 3'd0;
        rd_addr = 8'd0;
        tick();
        checks++;
        if (rd_data !== 16'h8000) begin
            errors++;
            $display("FAIL bank_a_read: data=%h want 8000", rd_data);
        end
        rd_ch = 3'd5;
        tick();
        rd_en = 1'b0;
        checks++;
        if (rd_data !== 16'h0 || rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL bad_ch: data=%h valid=%b want 0000 1", rd_data, rd_valid);
        end
    endtask

    initial begin
        rst = 1'b0;
        mic_data = '0;
        mic_valid = 1'b0;
        rd_ch = '0;
        rd_addr = '0;
        rd_en = 1'b0;
        buf_release = 1'b0;
        ovr_clr = 1'b0;
        test_reset();
        test_fill_a();
        test_fill_b_gaps();
        test_overrun();
        test_release_with_complete();
        test_reset_mid_fill();
        test_ovr_clr_and_bad_ch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multi_sampler.md
MULTI_SAMPLER -- requirements
Module: multi_sampler

Interface
REQ-001 Parameter N_CH, default 4, number of microphone channels captured per frame (>=1).
REQ-002 Parameter DATA_WIDTH, default 16, bits per sample.
REQ-003 Parameter SAMPLES_PER_BUF, default 256, frames per bank (power of two, >=4).
REQ-004 Parameter ADDR_WIDTH, default $clog2(SAMPLES_PER_BUF), read/write index width.
REQ-005 Parameter CH_W, default $clog2(N_CH>1?N_CH:2), channel-select width.
REQ-006 clk_i  in  1  single clock; all logic rising-edge.
REQ-007 rst_i  in  1  reset, synchronous, active-high.
REQ-008 mic_data_i  in  N_CH*DATA_WIDTH  packed frame; channel k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-009 mic_valid_i  in  1  frame strobe; all N_CH samples accepted together.
REQ-010 rd_ch_i  in  CH_W  read channel select.
REQ-011 rd_addr_i  in  ADDR_WIDTH  read frame index.
REQ-012 rd_en_i  in  1  read request.
REQ-013 buf_release_i  in  1  consumer finished with completed bank.
REQ-014 ovr_clr_i  in  1  clears overrun flag and counter.
REQ-015 rd_data_o  out  DATA_WIDTH  read sample.
REQ-016 rd_data_valid_o  out  1  rd_data_o valid.
REQ-017 buf_ready_pulse_o  out  1  one-cycle bank-complete strobe.
REQ-018 active_buf_o  out  1  bank currently being written (0=A, 1=B).
REQ-019 pending_o  out  1  completed bank held, awaiting release.
REQ-020 overrun_o  out  1  sticky overrun flag.
REQ-021 overrun_cnt_o  out  16  saturating overrun count.

Function
REQ-022 Storage: 2 banks x N_CH x SAMPLES_PER_BUF words of DATA_WIDTH; contents not reset.
REQ-023 Write index wr_idx (ADDR_WIDTH) counts accepted frames; on mic_valid_i=1, sample k written to [active_buf_o][k][wr_idx], wr_idx increments.
REQ-024 mic_valid_i=0: no write, no state change.
REQ-025 Bank-complete event: frame accepted with wr_idx=SAMPLES_PER_BUF-1; wr_idx wraps to 0 in all cases.
REQ-026 State machine, two states: FREE (pending_o=0), HELD (pending_o=1).
REQ-027 Complete in FREE: next cycle active_buf_o toggles, buf_ready_pulse_o=1 for exactly one cycle, state -> HELD.
REQ-028 Complete in HELD without simultaneous release: overrun; active_buf_o unchanged, same bank refilled from index 0, no pulse, overrun_o set, overrun_cnt_o +1 saturating at 16'hFFFF.
REQ-029 buf_release_i in HELD: state -> FREE next cycle; in FREE: ignored.
REQ-030 Release and complete in same cycle in HELD: release wins; treated as REQ-027 (swap, pulse, remain HELD), no overrun.
REQ-031 Reads always target bank ~active_buf_o as sampled in the request cycle; latency 1: rd_data_valid_o = rd_en_i delayed one cycle; rd_data_o = word [~active_buf_o][rd_ch_i][rd_addr_i].
REQ-032 rd_en_i=0: rd_data_o holds last value; rd_data_valid_o=0.
REQ-033 rd_ch_i >= N_CH: rd_data_o=0, rd_data_valid_o still asserted.
REQ-034 Reads permitted in either state; data in FREE is stale, not an error.
REQ-035 ovr_clr_i: overrun_o=0, overrun_cnt_o=0 next cycle; simultaneous overrun event: clear wins.
REQ-036 No combinational path from any input to any output.

Reset
REQ-037 rst_i=1 at a clock edge: active_buf_o=0, wr_idx=0, state FREE, pending_o=0, buf_ready_pulse_o=0, overrun_o=0, overrun_cnt_o=0, rd_data_o=0, rd_data_valid_o=0.
REQ-038 Reset mid-fill discards partial bank; first post-reset frame written to bank A index 0.
REQ-039 Inputs ignored while rst_i=1.

Verification
REQ-040 Reset, then 256 frames ch k = 16'h5000+16*i+k, valid continuous -> one pulse one cycle after frame 255, active_buf_o=1, pending_o=1; reading ch2 addr 10 returns 16'h50A2 one cycle later.
REQ-041 Release, then 256 frames with ~30% valid gaps -> exactly one pulse, active_buf_o=0; all 4x256 reads of bank B match golden values.
REQ-042 Without release, fill 3 more banks -> no pulses, overrun_o=1, overrun_cnt_o=3, active_buf_o unchanged, bank B contents intact.
REQ-043 Release asserted same cycle as frame 255 in HELD -> pulse, swap, overrun_cnt_o unchanged.
REQ-044 Assert rst_i after 100 frames -> all outputs at REQ-037 values; next 256 frames complete bank A with pulse at frame 255.
REQ-045 ovr_clr_i with concurrent overrun event -> overrun_o=0, overrun_cnt_o=0; rd_ch_i=5 with N_CH=4 -> rd_data_o=0, valid=1.
